// File: rtl/cacheline_adaptor_pkg.sv
// Shared types for the cache-line adaptor: the address type and the
// line/beat/state types. Optional feature macro: ADAPTOR_EARLY_RESP_EN.
package rv32i_types;
  typedef logic [31:0] addr_t;
endpackage : rv32i_types

package adaptor_types;
  import rv32i_types::*;

  localparam int BEATS  = 4;
  localparam int BEAT_W = 64;

  typedef logic [BEATS*BEAT_W-1:0] line_t;
  typedef logic [BEAT_W-1:0]       burst_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } adaptor_state_e;

  // Select 64-bit beat k out of a 256-bit line.
  function automatic burst_t get_beat(input line_t l, input logic [1:0] k);
    return l[int'(k)*BEAT_W +: BEAT_W];
  endfunction

  // Align a byte address down to the start of its 32-byte line.
  function automatic addr_t line_align(input addr_t a);
    return {a[31:5], 5'b0_0000};
  endfunction
endpackage : adaptor_types

// File: rtl/cacheline_adaptor_if.sv
// Bundle of cache-side and memory-side signals of the cache-line adaptor.
// slave  : the adaptor's view; master : the arbiter/memory environment view.
// Optional feature macro: ADAPTOR_EARLY_RESP_EN (no effect on this file).
interface cacheline_adaptor_if;
  import rv32i_types::*;
  import adaptor_types::*;

  line_t  cache_to_pmem;
  line_t  pmem_to_cache;
  addr_t  cache_address;
  logic   cache_read;
  logic   cache_write;
  logic   cache_resp;
  burst_t burst_i;
  burst_t burst_o;
  addr_t  mem_address;
  logic   mem_read;
  logic   mem_write;
  logic   mem_resp;

  modport slave (
    input  cache_to_pmem, cache_address, cache_read, cache_write,
    input  burst_i, mem_resp,
    output pmem_to_cache, cache_resp, burst_o, mem_address,
    output mem_read, mem_write
  );

  modport master (
    output cache_to_pmem, cache_address, cache_read, cache_write,
    output burst_i, mem_resp,
    input  pmem_to_cache, cache_resp, burst_o, mem_address,
    input  mem_read, mem_write
  );
endinterface : cacheline_adaptor_if

// File: rtl/cacheline_adaptor.sv
// Cache-line adaptor: converts one 256-bit line request into a 4-beat
// 64-bit memory burst (read assembly / write disassembly).
// Optional feature macro: ADAPTOR_EARLY_RESP_EN -- respond combinationally
// in the cycle of the final beat and skip the DONE state.
module cacheline_adaptor
  import rv32i_types::*;
  import adaptor_types::*;
(
  input  logic                clk,
  input  logic                rst,
  cacheline_adaptor_if.slave  bus
);

  adaptor_state_e r_state;
  logic [1:0]     r_k;
  line_t          r_wr_line;
  line_t          r_rd_line;
  addr_t          r_mem_address;
  logic           r_mem_read;
  logic           r_mem_write;
`ifndef ADAPTOR_EARLY_RESP_EN
  logic           r_cache_resp;
`endif

  logic w_busy;
  logic w_last_beat;

  assign w_busy      = (r_state == ST_READ) || (r_state == ST_WRITE);
  assign w_last_beat = w_busy && bus.mem_resp && (r_k == 2'd3);

  // Main FSM: request capture, beat counting, line assembly and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_k           <= 2'd0;
      r_wr_line     <= '0;
      r_rd_line     <= '0;
      r_mem_address <= 32'h0000_0000;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
`ifndef ADAPTOR_EARLY_RESP_EN
      r_cache_resp  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
`ifndef ADAPTOR_EARLY_RESP_EN
          r_cache_resp <= 1'b0;
`endif
          r_k <= 2'd0;
          if (bus.cache_write) begin
            // Write wins when both strobes are high.
            r_wr_line     <= bus.cache_to_pmem;
            r_mem_address <= line_align(bus.cache_address);
            r_mem_write   <= 1'b1;
            r_state       <= ST_WRITE;
          end else if (bus.cache_read) begin
            r_mem_address <= line_align(bus.cache_address);
            r_mem_read    <= 1'b1;
            r_state       <= ST_READ;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_READ: begin
          if (bus.mem_resp) begin
            r_rd_line[int'(r_k)*BEAT_W +: BEAT_W] <= bus.burst_i;
            r_k <= r_k + 2'd1;
            if (r_k == 2'd3) begin
              r_mem_read <= 1'b0;
`ifdef ADAPTOR_EARLY_RESP_EN
              r_state    <= ST_IDLE;
`else
              r_cache_resp <= 1'b1;
              r_state      <= ST_DONE;
`endif
            end else begin
              r_state <= ST_READ;
            end
          end else begin
            r_state <= ST_READ;
          end
        end

        ST_WRITE: begin
          if (bus.mem_resp) begin
            r_k <= r_k + 2'd1;
            if (r_k == 2'd3) begin
              r_mem_write <= 1'b0;
`ifdef ADAPTOR_EARLY_RESP_EN
              r_state     <= ST_IDLE;
`else
              r_cache_resp <= 1'b1;
              r_state      <= ST_DONE;
`endif
            end else begin
              r_state <= ST_WRITE;
            end
          end else begin
            r_state <= ST_WRITE;
          end
        end

        ST_DONE: begin
`ifndef ADAPTOR_EARLY_RESP_EN
          r_cache_resp <= 1'b0;
`endif
          r_state <= ST_IDLE;
        end

        default: begin
          r_state     <= ST_IDLE;
          r_k         <= 2'd0;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
`ifndef ADAPTOR_EARLY_RESP_EN
          r_cache_resp <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign bus.mem_address = r_mem_address;
  assign bus.mem_read    = r_mem_read;
  assign bus.mem_write   = r_mem_write;
  assign bus.burst_o     = get_beat(r_wr_line, r_k);

`ifdef ADAPTOR_EARLY_RESP_EN
  // The final read beat bypasses the buffer so the line is complete this cycle.
  assign bus.cache_resp    = w_last_beat;
  assign bus.pmem_to_cache = (w_last_beat && (r_state == ST_READ)) ?
                             {bus.burst_i, r_rd_line[3*BEAT_W-1:0]} : r_rd_line;
`else
  assign bus.cache_resp    = r_cache_resp;
  assign bus.pmem_to_cache = r_rd_line;
`endif

endmodule : cacheline_adaptor

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor. Expected responses are queued
// when a request is issued and popped when cache_resp is observed.
// Optional feature macro: ADAPTOR_EARLY_RESP_EN (changes expected latency).
module tb_cacheline_adaptor;

  typedef struct {
    bit           wr;
    logic [255:0] line;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];
  logic [255:0] last_rd;

  cacheline_adaptor_if bus();

  cacheline_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.cache_read = 1'b0; bus.cache_write = 1'b0; bus.mem_resp = 1'b0;
    bus.cache_address = 32'h0; bus.cache_to_pmem = 256'd0; bus.burst_i = 64'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if ({bus.cache_resp, bus.mem_read, bus.mem_write} !== 3'b000) begin
      n_fail++; $display("FAIL reset_strobes: got %b exp 000", {bus.cache_resp, bus.mem_read, bus.mem_write});
    end
    n_tests++;
    if (bus.mem_address !== 32'h0 || bus.burst_o !== 64'd0 || bus.pmem_to_cache !== 256'd0) begin
      n_fail++; $display("FAIL reset_data: addr %h burst_o %h pmem %h exp zeros", bus.mem_address, bus.burst_o, bus.pmem_to_cache);
    end
    last_rd = 256'd0;
  endtask

  task automatic test_idle_mem_resp();
    bus.mem_resp = 1'b1;
    bus.burst_i  = 64'hDEAD_BEEF_CAFE_F00D;
    repeat (3) @(negedge clk);
    bus.mem_resp = 1'b0;
    #1;
    n_tests++;
    if ({bus.cache_resp, bus.mem_read, bus.mem_write} !== 3'b000 || bus.pmem_to_cache !== 256'd0) begin
      n_fail++; $display("FAIL idle_ignore: strobes %b pmem %h exp 000 / 0", {bus.cache_resp, bus.mem_read, bus.mem_write}, bus.pmem_to_cache);
    end
  endtask

  // One complete transaction; pat[i] is mem_resp in the i-th busy cycle.
  task automatic run_txn(input string nm, input bit do_wr, input bit do_rd,
                         input logic [31:0] addr, input logic [255:0] line,
                         input logic [7:0] pat, input int npat, input bit hold);
    int k; int cyc; int resp_cyc; int wr_cyc; int exp_lat;
    bit got;
    logic [255:0] cap;
    logic [255:0] exp_line;
    logic [31:0]  exp_addr;
    exp_t e;
    e.wr = do_wr; e.line = line;
    exp_q.push_back(e);
    exp_addr = {addr[31:5], 5'b0_0000};
    bus.cache_address = addr;
    bus.cache_to_pmem = do_wr ? line : 256'd0;
    bus.cache_write   = do_wr;
    bus.cache_read    = do_rd;
    k = 0; resp_cyc = 0; wr_cyc = 0; got = 1'b0; cap = 256'd0;
    @(negedge clk);
    cyc = 2;
    for (int i = 0; i < npat; i++) begin
      bus.mem_resp = pat[i];
      bus.burst_i  = (k < 4) ? line[k*64 +: 64] : 64'd0;
      #1;
      if (bus.mem_write === 1'b1) wr_cyc++;
      n_tests++;
      if (bus.mem_read !== ~do_wr || bus.mem_write !== do_wr) begin
        n_fail++; $display("FAIL %s_strobe: cyc %0d rd/wr %b%b exp %b%b", nm, cyc, bus.mem_read, bus.mem_write, ~do_wr, do_wr);
      end
      n_tests++;
      if (bus.mem_address !== exp_addr) begin
        n_fail++; $display("FAIL %s_addr: cyc %0d got %h exp %h", nm, cyc, bus.mem_address, exp_addr);
      end
      if (do_wr && k < 4) begin
        n_tests++;
        if (bus.burst_o !== line[k*64 +: 64]) begin
          n_fail++; $display("FAIL %s_burst_o: beat %0d got %h exp %h", nm, k, bus.burst_o, line[k*64 +: 64]);
        end
      end
`ifdef ADAPTOR_EARLY_RESP_EN
      if (k == 3 && pat[i]) begin
        got = (bus.cache_resp === 1'b1);
        resp_cyc = cyc;
        cap = bus.pmem_to_cache;
      end else begin
        n_tests++;
        if (bus.cache_resp !== 1'b0) begin
          n_fail++; $display("FAIL %s_early_resp: cyc %0d got %b exp 0", nm, cyc, bus.cache_resp);
        end
      end
`else
      n_tests++;
      if (bus.cache_resp !== 1'b0) begin
        n_fail++; $display("FAIL %s_early_resp: cyc %0d got %b exp 0", nm, cyc, bus.cache_resp);
      end
`endif
      @(negedge clk);
      cyc++;
      if (pat[i]) k++;
    end
    bus.mem_resp = 1'b0;
`ifdef ADAPTOR_EARLY_RESP_EN
    exp_lat = npat + 1;
`else
    exp_lat = npat + 2;
    #1;
    got = (bus.cache_resp === 1'b1);
    resp_cyc = cyc;
    cap = bus.pmem_to_cache;
`endif
    if (!hold) begin
      bus.cache_read = 1'b0; bus.cache_write = 1'b0;
    end
`ifndef ADAPTOR_EARLY_RESP_EN
    @(negedge clk);
`endif
    #1;
    n_tests++;
    if (!got) begin
      n_fail++; $display("FAIL %s_resp: got none exp cache_resp at cyc %0d", nm, exp_lat);
    end
    n_tests++;
    if (resp_cyc != exp_lat) begin
      n_fail++; $display("FAIL %s_latency: got %0d exp %0d", nm, resp_cyc, exp_lat);
    end
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL %s_scoreboard: got response exp empty queue", nm);
    end else begin
      e = exp_q.pop_front();
      exp_line = e.wr ? last_rd : e.line;
      if (cap !== exp_line) begin
        n_fail++; $display("FAIL %s_line: got %h exp %h", nm, cap, exp_line);
      end
      if (!e.wr) last_rd = e.line;
    end
    n_tests++;
    if ({bus.cache_resp, bus.mem_read, bus.mem_write} !== 3'b000) begin
      n_fail++; $display("FAIL %s_after: strobes %b exp 000", nm, {bus.cache_resp, bus.mem_read, bus.mem_write});
    end
    n_tests++;
    if (bus.pmem_to_cache !== last_rd) begin
      n_fail++; $display("FAIL %s_hold: got %h exp %h", nm, bus.pmem_to_cache, last_rd);
    end
    if (do_wr) begin
      n_tests++;
      if (wr_cyc != npat) begin
        n_fail++; $display("FAIL %s_wr_cycles: got %0d exp %0d", nm, wr_cyc, npat);
      end
    end
  endtask

  task automatic test_read();
    run_txn("read", 1'b0, 1'b1, 32'h0000_1234,
            {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 8'b0000_1111, 4, 1'b0);
  endtask

  task automatic test_write_gapped();
    run_txn("write_gap", 1'b1, 1'b0, 32'h8000_0040,
            {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, 8'b0010_1101, 6, 1'b0);
  endtask

  task automatic test_read_write_both();
    run_txn("both", 1'b1, 1'b1, 32'h0000_2000,
            {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_1234_5678},
            8'b0000_1111, 4, 1'b0);
  endtask

  task automatic test_reset_midburst();
    logic [255:0] l;
    l = {64'h9999_0000_9999_0000, 64'h8888_0000_8888_0000, 64'h7777_0000_7777_0000, 64'h6666_0000_6666_0000};
    bus.cache_address = 32'h0000_3000; bus.cache_read = 1'b1; bus.cache_write = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      bus.mem_resp = 1'b1; bus.burst_i = l[i*64 +: 64];
      @(negedge clk);
    end
    rst = 1'b1; bus.mem_resp = 1'b0; bus.cache_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if ({bus.cache_resp, bus.mem_read, bus.mem_write} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_strobes: got %b exp 000", {bus.cache_resp, bus.mem_read, bus.mem_write});
    end
    n_tests++;
    if (bus.pmem_to_cache !== 256'd0 || bus.mem_address !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_clear: pmem %h addr %h exp 0", bus.pmem_to_cache, bus.mem_address);
    end
    last_rd = 256'd0;
    @(negedge clk);
    run_txn("read_after_rst", 1'b0, 1'b1, 32'h0000_301C, l, 8'b0001_1011, 5, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_rd0", 1'b0, 1'b1, 32'h0000_4000,
            {64'h1, 64'h2, 64'h3, 64'h4}, 8'b0000_1111, 4, 1'b1);
    run_txn("b2b_wr", 1'b1, 1'b0, 32'h0000_5020,
            {64'hA1, 64'hB2, 64'hC3, 64'hD4}, 8'b0000_1111, 4, 1'b1);
    run_txn("b2b_rd1", 1'b0, 1'b1, 32'hFFFF_FFE4,
            {64'hCAFE, 64'hBABE, 64'hFACE, 64'hFEED}, 8'b0001_0111, 5, 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_idle_mem_resp();
    test_read();
    test_write_gapped();
    test_read_write_both();
    test_reset_midburst();
    test_back_to_back();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d pending exp 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_cacheline_adaptor

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port cache_to_pmem, input, line_t (256): write line from the arbiter.
REQ-004 SHALL have port pmem_to_cache, output, line_t (256): assembled read line to the arbiter.
REQ-005 SHALL have port cache_address, input, addr_t (32): request address.
REQ-006 SHALL have ports cache_read and cache_write, input, 1 bit each: request strobes, held until cache_resp.
REQ-007 SHALL have port cache_resp, output, 1 bit: one-cycle completion pulse.
REQ-008 SHALL have ports burst_i (input) and burst_o (output), burst_t (64) each: memory beat data.
REQ-009 SHALL have port mem_address, output, addr_t (32): line-aligned burst address.
REQ-010 SHALL have ports mem_read and mem_write, output, 1 bit each: burst request to memory.
REQ-011 SHALL have port mem_resp, input, 1 bit: one beat accepted or valid this cycle.

Function
REQ-012 SHALL implement the FSM IDLE, READ, WRITE, DONE, with a 2-bit beat counter.
REQ-013 In IDLE, on an edge with cache_write=1, SHALL latch cache_to_pmem and cache_address and go to WRITE; write wins if read and write are both high.
REQ-014 In IDLE, on an edge with cache_read=1 and cache_write=0, SHALL latch cache_address and go to READ.
REQ-015 mem_address SHALL be {latched_addr[31:5], 5'b0}; it SHALL be stable throughout READ and WRITE.
REQ-016 mem_read SHALL be 1 only in READ, and mem_write SHALL be 1 only in WRITE; both are Moore outputs of the state.
REQ-017 In READ, on each edge with mem_resp=1, SHALL store burst_i into line bits [64k+63:64k], where k is the counter, then increment k.
REQ-018 In WRITE, burst_o SHALL equal line bits [64k+63:64k]; on each edge with mem_resp=1, k SHALL increment.
REQ-019 Beats need not be consecutive; cycles with mem_resp=0 SHALL stall without changing k or the data.
REQ-020 On the edge that accepts beat k=3, SHALL go to DONE and wrap k to 0.
REQ-021 In DONE, cache_resp SHALL be 1 for exactly one cycle, and pmem_to_cache SHALL hold the full line; the next state is always IDLE.
REQ-022 pmem_to_cache SHALL hold the last read line until the next read overwrites it; a write SHALL NOT alter pmem_to_cache.
REQ-023 mem_resp SHALL be ignored in IDLE and DONE.
REQ-024 With 4 consecutive mem_resp cycles, total latency SHALL be 6 cycles from request edge to cache_resp: 1 accept, 4 beats, 1 DONE.
REQ-025 Back-to-back requests SHALL be legal; a request held through DONE SHALL be re-sampled in IDLE as a new transaction.

Reset
REQ-026 On rst=1 at an edge, in any state, SHALL enter IDLE with k=0.
REQ-027 After reset, SHALL drive cache_resp, mem_read and mem_write to 0 and clear the line buffer, pmem_to_cache, burst_o and mem_address to 0.
REQ-028 Reset mid-burst SHALL abort the transaction with no cache_resp; memory sees mem_read or mem_write drop the next cycle.

Configuration
REQ-029 Macro ADAPTOR_EARLY_RESP_EN, when defined, SHALL make the read path assert cache_resp combinationally in the READ cycle where k=3 and mem_resp=1.
REQ-030 In that early-response cycle, pmem_to_cache SHALL be {burst_i, buffered beats 2..0}, and the FSM SHALL return directly to IDLE. Write responses behave the same way in the WRITE k=3 cycle.
REQ-031 With ADAPTOR_EARLY_RESP_EN undefined, the DONE-state behaviour of REQ-021 and REQ-024 SHALL apply.

Structure
REQ-032 Package adaptor_types SHALL hold line_t, burst_t, BEATS=4, BEAT_W=64 and the adaptor state enum; addr_t SHALL come from rv32i_types.
REQ-033 The block SHALL be a single module with no sub-module; the line buffer and counter are inline.

Verification
REQ-034 Reset then idle: after rst, all outputs are 0; with mem_resp=1 in IDLE, nothing changes.
REQ-035 Read at 0x0000_1234 with 4 consecutive beats of 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> mem_address=0x0000_1220; pmem_to_cache=0x44..44_33..33_22..22_11..11; cache_resp on cycle 6.
REQ-036 Write at 0x8000_0040 with line 0xDDDD_CCCC_BBBB_AAAA per beat pattern and mem_resp gapped (1,0,1,1,0,1) -> burst_o steps beats 0..3 only on mem_resp edges; mem_write stays high for 6 cycles; single cache_resp.
REQ-037 cache_read=1 and cache_write=1 together -> write transaction only; pmem_to_cache unchanged.
REQ-038 rst asserted after beat 1 of a read -> no cache_resp; mem_read=0 the next cycle; a following read completes correctly with k restarted at 0.
REQ-039 ADAPTOR_EARLY_RESP_EN defined, read with 4 consecutive beats -> cache_resp in the 4th beat cycle (latency 5), carrying the correct line.
